// File: rtl/pc_predictor_pkg.sv
// Shared Y86-64 encodings and branch-predictor helper types/functions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_predictor_pkg;

  // Instruction codes shared by every pipeline stage.
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // ifun of an unconditional jmp.
  localparam logic [3:0] FJMP = 4'h0;

  // Pipeline status codes.
  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  // 2-bit saturating counter states; MSB is the taken prediction.
  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

  // How the fetch-stage prediction for an instruction is formed.
  typedef enum logic [1:0] {
    PRED_NEVER   = 2'd0,
    PRED_ALWAYS  = 2'd1,
    PRED_DYNAMIC = 2'd2
  } pred_kind_e;

  // Calls and unconditional jumps always redirect; conditional jumps
  // consult the table; everything else falls through.
  function automatic pred_kind_e pred_kind(input logic [3:0] icode,
                                           input logic [3:0] ifun);
    pred_kind_e kind;
    kind = PRED_NEVER;
    if (icode == ICALL) begin
      kind = PRED_ALWAYS;
    end else if (icode == IJXX) begin
      kind = (ifun == FJMP) ? PRED_ALWAYS : PRED_DYNAMIC;
    end
    return kind;
  endfunction

  // One saturating step of a 2-bit counter toward the resolved outcome.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr,
                                          input logic       taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != CTR_STRONG_T) begin
      nxt = ctr + 2'd1;
    end else if (!taken && ctr != CTR_STRONG_NT) begin
      nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pc_predictor_if.sv
// Bundle between the pipeline (fetch, M, W stages) and the PC predictor.
// Latency: n/a (wires only).
// Backpressure: F_stall_i freezes the predicted PC; no other flow control.
interface pc_predictor_if;

  // Fetch stage
  logic        F_stall_i;
  logic [3:0]  f_icode_i;
  logic [3:0]  f_ifun_i;
  logic [63:0] f_valC_i;
  logic [63:0] f_valP_i;

  // Memory stage branch resolution
  logic        M_jxx_i;
  logic        M_cond_i;
  logic        M_cnd_i;
  logic        M_pred_taken_i;
  logic [63:0] M_pc_i;
  logic [63:0] M_valC_i;
  logic [63:0] M_valP_i;

  // Write-back return
  logic        W_ret_i;
  logic [63:0] W_valM_i;

  // Predictor results
  logic [63:0] f_pc_o;
  logic        f_pred_taken_o;
  logic        mispredict_o;
  logic [31:0] perf_jxx_o;
  logic [31:0] perf_miss_o;

  // Pipeline side: drives stage info, consumes fetch address and status.
  modport master (
    output F_stall_i, f_icode_i, f_ifun_i, f_valC_i, f_valP_i,
    output M_jxx_i, M_cond_i, M_cnd_i, M_pred_taken_i,
    output M_pc_i, M_valC_i, M_valP_i,
    output W_ret_i, W_valM_i,
    input  f_pc_o, f_pred_taken_o, mispredict_o, perf_jxx_o, perf_miss_o
  );

  // Predictor side.
  modport slave (
    input  F_stall_i, f_icode_i, f_ifun_i, f_valC_i, f_valP_i,
    input  M_jxx_i, M_cond_i, M_cnd_i, M_pred_taken_i,
    input  M_pc_i, M_valC_i, M_valP_i,
    input  W_ret_i, W_valM_i,
    output f_pc_o, f_pred_taken_o, mispredict_o, perf_jxx_o, perf_miss_o
  );

endinterface

// File: rtl/pc_predictor_pht.sv
// Pattern history table of 2-bit saturating counters, one read and one update port.
// Latency: read is combinational; update lands on the next rising edge.
// Backpressure: none; an update is accepted every cycle it is presented.
module pht_2bit
  import pc_predictor_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output logic [1:0]          o_rd_ctr,
  input  logic                i_upd_vld,
  input  logic [IDX_BITS-1:0] i_upd_idx,
  input  logic                i_upd_taken
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0] r_ctr [ENTRIES];

  // Read straight off the registers so a same-cycle update to the same
  // entry is only visible from the following cycle.
  assign o_rd_ctr = r_ctr[i_rd_idx];

  // Reset every entry to weakly-taken; otherwise train one entry per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= CTR_WEAK_T;
      end
    end else if (i_upd_vld) begin
      r_ctr[i_upd_idx] <= ctr_step(r_ctr[i_upd_idx], i_upd_taken);
    end
  end

endmodule

// File: rtl/pc_predictor.sv
// Fetch PC selection with 2-bit dynamic prediction for conditional jumps plus perf counters.
// Latency: prediction and redirects are combinational in the fetch cycle; state updates next edge.
// Backpressure: F_stall_i holds the predicted PC; table training and perf counting continue.
module pc_predictor
  import pc_predictor_pkg::*;
#(
  parameter int          PHT_BITS     = 4,
  parameter logic [31:0] PERF_RST_VAL = 32'h0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pc_predictor_if.slave  pred_if
);

  logic [63:0]         r_pred_pc;
  logic [31:0]         r_perf_jxx;
  logic [31:0]         r_perf_miss;

  logic                w_mispredict;
  logic [63:0]         w_fix_pc;
  logic [63:0]         w_f_pc;
  logic [1:0]          w_pht_ctr;
  logic                w_pred_taken;
  logic                w_upd_vld;
  logic [PHT_BITS-1:0] w_rd_idx;
  logic [PHT_BITS-1:0] w_upd_idx;

  // A jump in M whose resolved direction disagrees with its fetch-time guess.
  assign w_mispredict = pred_if.M_jxx_i && (pred_if.M_cnd_i != pred_if.M_pred_taken_i);

  // Fetch address: branch repair beats a return, which beats the prediction.
  always_comb begin
    w_fix_pc = pred_if.M_cnd_i ? pred_if.M_valC_i : pred_if.M_valP_i;
    w_f_pc   = r_pred_pc;
    if (w_mispredict) begin
      w_f_pc = w_fix_pc;
    end else if (pred_if.W_ret_i) begin
      w_f_pc = pred_if.W_valM_i;
    end
  end

  assign w_rd_idx  = w_f_pc[PHT_BITS-1:0];
  assign w_upd_idx = pred_if.M_pc_i[PHT_BITS-1:0];
  assign w_upd_vld = pred_if.M_jxx_i && pred_if.M_cond_i;

  pht_2bit #(
    .IDX_BITS (PHT_BITS)
  ) u_pht (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_rd_idx    (w_rd_idx),
    .o_rd_ctr    (w_pht_ctr),
    .i_upd_vld   (w_upd_vld),
    .i_upd_idx   (w_upd_idx),
    .i_upd_taken (pred_if.M_cnd_i)
  );

  // Direction guess for the instruction being fetched at w_f_pc.
  always_comb begin
    w_pred_taken = 1'b0;
    unique case (pred_kind(pred_if.f_icode_i, pred_if.f_ifun_i))
      PRED_ALWAYS:  w_pred_taken = 1'b1;
      PRED_DYNAMIC: w_pred_taken = w_pht_ctr[1];
      default:      w_pred_taken = 1'b0;
    endcase
  end

  // Predicted next fetch address, frozen while fetch is stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pred_pc <= 64'h0;
    end else if (!pred_if.F_stall_i) begin
      r_pred_pc <= w_pred_taken ? pred_if.f_valC_i : pred_if.f_valP_i;
    end
  end

  // Saturating event counters for resolved jumps and mispredictions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_jxx  <= PERF_RST_VAL;
      r_perf_miss <= PERF_RST_VAL;
    end else begin
      if (pred_if.M_jxx_i && r_perf_jxx != PERF_MAX) begin
        r_perf_jxx <= r_perf_jxx + 32'd1;
      end
      if (w_mispredict && r_perf_miss != PERF_MAX) begin
        r_perf_miss <= r_perf_miss + 32'd1;
      end
    end
  end

  assign pred_if.f_pc_o         = w_f_pc;
  assign pred_if.f_pred_taken_o = w_pred_taken;
  assign pred_if.mispredict_o   = w_mispredict;
  assign pred_if.perf_jxx_o     = r_perf_jxx;
  assign pred_if.perf_miss_o    = r_perf_miss;

endmodule

// File: tb/tb_pc_predictor.sv
// Bench for pc_predictor: directed scenarios with literal expectations plus randomized traffic.
// Latency: outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: F_stall_i randomized; a second instance starts its perf counters near saturation.
module tb_pc_predictor;
  import pc_predictor_pkg::*;

  localparam int          TB_PHT     = 4;
  localparam int          TB_ENTRIES = 16;
  localparam logic [31:0] SAT_START  = 32'hFFFF_FFF0;
  localparam longint      SAT_MAX    = 64'h0000_0000_FFFF_FFFF;

  logic clk_i;
  logic rst_i;

  int n_checks;
  int n_fail;

  pc_predictor_if u_if ();
  pc_predictor_if u_if2 ();

  pc_predictor #(.PHT_BITS(TB_PHT)) u_dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pred_if (u_if)
  );

  pc_predictor #(.PHT_BITS(TB_PHT), .PERF_RST_VAL(SAT_START)) u_dut_sat (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pred_if (u_if2)
  );

  // Second instance sees exactly the same stimulus.
  assign u_if2.F_stall_i      = u_if.F_stall_i;
  assign u_if2.f_icode_i      = u_if.f_icode_i;
  assign u_if2.f_ifun_i       = u_if.f_ifun_i;
  assign u_if2.f_valC_i       = u_if.f_valC_i;
  assign u_if2.f_valP_i       = u_if.f_valP_i;
  assign u_if2.M_jxx_i        = u_if.M_jxx_i;
  assign u_if2.M_cond_i       = u_if.M_cond_i;
  assign u_if2.M_cnd_i        = u_if.M_cnd_i;
  assign u_if2.M_pred_taken_i = u_if.M_pred_taken_i;
  assign u_if2.M_pc_i         = u_if.M_pc_i;
  assign u_if2.M_valC_i       = u_if.M_valC_i;
  assign u_if2.M_valP_i       = u_if.M_valP_i;
  assign u_if2.W_ret_i        = u_if.W_ret_i;
  assign u_if2.W_valM_i       = u_if.W_valM_i;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_valid;
  logic [63:0] m_pred_pc;
  int          m_ctr [TB_ENTRIES];
  longint      m_jxx, m_miss, m_jxx2, m_miss2;

  function automatic longint sat_inc(input longint v);
    return (v >= SAT_MAX) ? SAT_MAX : v + 1;
  endfunction

  // Every falling edge: check outputs, then advance the model to the next rising edge.
  always @(negedge clk_i) begin
    logic        exp_mis;
    logic [63:0] exp_pc;
    logic        exp_pt;
    int          idx;
    int          mi;
    exp_mis = u_if.M_jxx_i && (u_if.M_cnd_i != u_if.M_pred_taken_i);
    if (exp_mis)           exp_pc = u_if.M_cnd_i ? u_if.M_valC_i : u_if.M_valP_i;
    else if (u_if.W_ret_i) exp_pc = u_if.W_valM_i;
    else                   exp_pc = m_pred_pc;
    idx = int'(exp_pc % 64'd16);
    if (u_if.f_icode_i == ICALL)     exp_pt = 1'b1;
    else if (u_if.f_icode_i == IJXX) exp_pt = (u_if.f_ifun_i == 4'd0) || (m_ctr[idx] >= 2);
    else                             exp_pt = 1'b0;

    if (m_valid) begin
      chk("f_pc",        u_if.f_pc_o,          exp_pc);
      chk("pred_taken",  64'(u_if.f_pred_taken_o), 64'(exp_pt));
      chk("mispredict",  64'(u_if.mispredict_o),   64'(exp_mis));
      chk("perf_jxx",    64'(u_if.perf_jxx_o),     64'(m_jxx));
      chk("perf_miss",   64'(u_if.perf_miss_o),    64'(m_miss));
      chk("f_pc2",       u_if2.f_pc_o,         exp_pc);
      chk("pred_taken2", 64'(u_if2.f_pred_taken_o), 64'(exp_pt));
      chk("perf_jxx2",   64'(u_if2.perf_jxx_o),     64'(m_jxx2));
      chk("perf_miss2",  64'(u_if2.perf_miss_o),    64'(m_miss2));
    end

    if (rst_i) begin
      m_valid   = 1'b1;
      m_pred_pc = 64'h0;
      for (int i = 0; i < TB_ENTRIES; i++) m_ctr[i] = 2;
      m_jxx  = 0;
      m_miss = 0;
      m_jxx2  = longint'(SAT_START);
      m_miss2 = longint'(SAT_START);
    end else begin
      if (!u_if.F_stall_i) m_pred_pc = exp_pt ? u_if.f_valC_i : u_if.f_valP_i;
      if (u_if.M_jxx_i && u_if.M_cond_i) begin
        mi = int'(u_if.M_pc_i % 64'd16);
        if (u_if.M_cnd_i) m_ctr[mi] = (m_ctr[mi] == 3) ? 3 : m_ctr[mi] + 1;
        else              m_ctr[mi] = (m_ctr[mi] == 0) ? 0 : m_ctr[mi] - 1;
      end
      if (u_if.M_jxx_i) begin
        m_jxx  = sat_inc(m_jxx);
        m_jxx2 = sat_inc(m_jxx2);
      end
      if (exp_mis) begin
        m_miss  = sat_inc(m_miss);
        m_miss2 = sat_inc(m_miss2);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_fetch(input logic [3:0] ic, input logic [3:0] fn,
                           input logic [63:0] vc, input logic [63:0] vp);
    u_if.f_icode_i = ic;
    u_if.f_ifun_i  = fn;
    u_if.f_valC_i  = vc;
    u_if.f_valP_i  = vp;
  endtask

  task automatic set_m(input logic jxx, input logic cond, input logic cnd, input logic pt,
                       input logic [63:0] pc, input logic [63:0] vc, input logic [63:0] vp);
    u_if.M_jxx_i        = jxx;
    u_if.M_cond_i       = cond;
    u_if.M_cnd_i        = cnd;
    u_if.M_pred_taken_i = pt;
    u_if.M_pc_i         = pc;
    u_if.M_valC_i       = vc;
    u_if.M_valP_i       = vp;
  endtask

  task automatic clr_m();
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
  endtask

  // ---------------- directed then random stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_valid  = 1'b0;
    rst_i    = 1'b1;
    u_if.F_stall_i = 1'b0;
    u_if.W_ret_i   = 1'b0;
    u_if.W_valM_i  = 64'h0;
    set_fetch(INOP, 4'h0, 64'h0, 64'h0);
    clr_m();
    step();
    @(negedge clk_i);
    chk("rst_f_pc",      u_if.f_pc_o, 64'h0);
    chk("rst_perf_jxx",  64'(u_if.perf_jxx_o), 64'h0);
    chk("rst_perf_miss", 64'(u_if.perf_miss_o), 64'h0);
    step();
    rst_i = 1'b0;

    // Sequential nop stream from address 0, last one jumps to 0x10.
    for (int i = 0; i < 5; i++) begin
      set_fetch(INOP, 4'h0, 64'h0, (i == 4) ? 64'h10 : 64'(i + 1));
      @(negedge clk_i);
      chk("nop_seq_pc", u_if.f_pc_o, 64'(i));
      step();
    end

    // Conditional jump with fresh (weakly taken) counter.
    set_fetch(IJXX, 4'h1, 64'h40, 64'h19);
    @(negedge clk_i);
    chk("jxx_fresh_pc", u_if.f_pc_o, 64'h10);
    chk("jxx_fresh_pred", 64'(u_if.f_pred_taken_o), 64'h1);
    step();

    // Resolves not-taken: redirect to fall-through.
    set_fetch(INOP, 4'h0, 64'h0, 64'h10);
    set_m(1'b1, 1'b1, 1'b0, 1'b1, 64'h10, 64'h40, 64'h19);
    @(negedge clk_i);
    chk("miss_flag", 64'(u_if.mispredict_o), 64'h1);
    chk("miss_redirect_pc", u_if.f_pc_o, 64'h19);
    step();

    // Counter now weakly not-taken; second not-taken resolution drives it to 0.
    clr_m();
    set_fetch(IJXX, 4'h1, 64'h40, 64'h19);
    set_m(1'b1, 1'b1, 1'b0, 1'b0, 64'h10, 64'h40, 64'h19);
    @(negedge clk_i);
    chk("wnt_pc", u_if.f_pc_o, 64'h10);
    chk("wnt_pred", 64'(u_if.f_pred_taken_o), 64'h0);
    chk("no_miss", 64'(u_if.mispredict_o), 64'h0);
    step();
    clr_m();
    set_fetch(INOP, 4'h0, 64'h0, 64'h10);
    @(negedge clk_i);
    chk("fallthru_pc", u_if.f_pc_o, 64'h19);
    step();

    // Four taken resolutions: 00 -> 01 -> 10 -> 11 -> 11.
    set_fetch(IJXX, 4'h1, 64'h40, 64'h19);
    set_m(1'b1, 1'b1, 1'b1, 1'b1, 64'h10, 64'h40, 64'h19);
    @(negedge clk_i);
    chk("snt_pred", 64'(u_if.f_pred_taken_o), 64'h0);
    step();
    set_fetch(INOP, 4'h0, 64'h0, 64'h20);
    step();
    set_fetch(INOP, 4'h0, 64'h0, 64'h21);
    step();
    set_fetch(INOP, 4'h0, 64'h0, 64'h10);
    @(negedge clk_i);
    chk("train_pc", u_if.f_pc_o, 64'h21);
    step();
    clr_m();
    set_fetch(IJXX, 4'h1, 64'h50, 64'h19);
    @(negedge clk_i);
    chk("st_pred", 64'(u_if.f_pred_taken_o), 64'h1);
    step();

    // Mispredict and ret together: branch repair wins.
    set_fetch(INOP, 4'h0, 64'h0, 64'h41);
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 64'h10, 64'h40, 64'h19);
    u_if.W_ret_i  = 1'b1;
    u_if.W_valM_i = 64'h80;
    @(negedge clk_i);
    chk("miss_over_ret", u_if.f_pc_o, 64'h40);
    step();
    clr_m();
    @(negedge clk_i);
    chk("ret_pc", u_if.f_pc_o, 64'h80);
    step();
    u_if.W_ret_i = 1'b0;

    // Stall for three cycles while M keeps training idx 0 toward not-taken.
    u_if.F_stall_i = 1'b1;
    set_fetch(INOP, 4'h0, 64'h0, 64'h99);
    set_m(1'b1, 1'b1, 1'b0, 1'b0, 64'h10, 64'h40, 64'h19);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_pc", u_if.f_pc_o, 64'h41);
      step();
    end
    u_if.F_stall_i = 1'b0;
    clr_m();
    set_fetch(INOP, 4'h0, 64'h0, 64'h10);
    step();
    set_fetch(IJXX, 4'h2, 64'h40, 64'h19);
    @(negedge clk_i);
    chk("stall_trained_pred", 64'(u_if.f_pred_taken_o), 64'h0);
    step();
    set_fetch(INOP, 4'h0, 64'h0, 64'h30);
    step();
    set_fetch(IJXX, 4'h0, 64'h60, 64'h39);
    @(negedge clk_i);
    chk("jmp_pred", 64'(u_if.f_pred_taken_o), 64'h1);
    step();
    set_fetch(ICALL, 4'h0, 64'h70, 64'h69);
    @(negedge clk_i);
    chk("call_pc", u_if.f_pc_o, 64'h60);
    chk("call_pred", 64'(u_if.f_pred_taken_o), 64'h1);
    step();
    set_fetch(INOP, 4'h0, 64'h0, 64'h71);
    @(negedge clk_i);
    chk("call_target_pc", u_if.f_pc_o, 64'h70);
    chk("perf_jxx_lit", 64'(u_if.perf_jxx_o), 64'd10);
    chk("perf_miss_lit", 64'(u_if.perf_miss_o), 64'd2);
    chk("perf_jxx2_lit", 64'(u_if2.perf_jxx_o), 64'hFFFF_FFFA);
    chk("perf_miss2_lit", 64'(u_if2.perf_miss_o), 64'hFFFF_FFF2);
    step();

    // Randomized traffic; occasional resets only in the early part.
    for (int i = 0; i < 3000; i++) begin
      rst_i          = (i < 2700) && ($urandom_range(0, 399) == 0);
      u_if.F_stall_i = ($urandom_range(0, 3) == 0);
      u_if.f_icode_i = ($urandom_range(0, 2) == 0) ? IJXX : 4'($urandom_range(0, 15));
      u_if.f_ifun_i  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 6));
      u_if.f_valC_i  = 64'($urandom_range(0, 255));
      u_if.f_valP_i  = 64'($urandom_range(0, 255));
      set_m($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            64'($urandom_range(0, 255)), {$urandom, $urandom}, {$urandom, $urandom});
      u_if.W_ret_i   = ($urandom_range(0, 7) == 0);
      u_if.W_valM_i  = {$urandom, $urandom};
      step();
    end
    rst_i = 1'b0;
    clr_m();
    u_if.W_ret_i = 1'b0;
    @(negedge clk_i);
    chk("sat_perf_miss", 64'(u_if2.perf_miss_o), 64'hFFFF_FFFF);
    chk("sat_perf_jxx",  64'(u_if2.perf_jxx_o),  64'hFFFF_FFFF);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_predictor.md
PC_PREDICTOR -- requirements
Module: pc_predictor

Interface
REQ-001 SHALL expose clk_i input 1 system clock; all state updates on its rising edge.
REQ-002 SHALL expose rst_i input 1; reset is synchronous and active-high.
REQ-003 SHALL expose F_stall_i input 1: hold F register (predicted PC).
REQ-004 SHALL expose f_icode_i/f_ifun_i input 4/4: icode/ifun of the instruction fetched at f_pc_o this cycle.
REQ-005 SHALL expose f_valC_i/f_valP_i input 64/64: fetched constant and fall-through address.
REQ-006 SHALL expose M_jxx_i input 1: M stage holds a jXX.
REQ-007 SHALL expose M_cond_i input 1: that jXX is conditional (ifun != 0).
REQ-008 SHALL expose M_cnd_i/M_pred_taken_i input 1/1: resolved outcome and the prediction made at fetch.
REQ-009 SHALL expose M_pc_i/M_valC_i/M_valP_i input 64 each: jXX address, target, fall-through.
REQ-010 SHALL expose W_ret_i input 1 and W_valM_i input 64: ret in W and its return address.
REQ-011 SHALL expose f_pc_o output 64: address fed to fetch.
REQ-012 SHALL expose f_pred_taken_o output 1: prediction for the instruction at f_pc_o, carried down the pipe.
REQ-013 SHALL expose mispredict_o output 1 to pipeline control; perf_jxx_o/perf_miss_o output 32/32 counters.
REQ-014 SHALL take parameter PHT_BITS, default 4: log2 of prediction-table entries.

Function
REQ-015 f_pc_o SHALL be combinational: mispredict ? (M_cnd_i ? M_valC_i : M_valP_i) : W_ret_i ? W_valM_i : predPC; mispredict has priority over ret.
REQ-016 mispredict_o SHALL equal M_jxx_i && (M_cnd_i != M_pred_taken_i).
REQ-017 Table SHALL hold 2^PHT_BITS 2-bit saturating counters indexed by address bits [PHT_BITS-1:0].
REQ-018 f_pred_taken_o SHALL be 1 for call, 1 for jXX with ifun 0, counter[f_pc_o idx][1] for conditional jXX, 0 otherwise.
REQ-019 Next predPC SHALL be f_valC_i when f_pred_taken_o, else f_valP_i; loaded each cycle F_stall_i is 0, held when 1.
REQ-020 On M_jxx_i && M_cond_i, counter[M_pc_i idx] SHALL increment if M_cnd_i, else decrement, saturating at 3/0; independent of F_stall_i.
REQ-021 Same-index lookup and update in one cycle SHALL read the pre-update counter value.
REQ-022 perf_jxx_o SHALL increment per M_jxx_i cycle; perf_miss_o per mispredict_o cycle; both saturate at 32'hFFFF_FFFF.
REQ-023 Latency: prediction same cycle as fetch; redirect to fetch same cycle as M resolution; zero bubbles added by this block.

Reset
REQ-024 On rst_i: predPC = 64'h0, all counters = 2'b10 (weakly taken), perf counters = 0.
REQ-025 rst_i SHALL override stall and update in the same cycle; mid-operation reset discards pending updates.
REQ-026 Outputs during reset cycle SHALL reflect combinational inputs; first post-reset f_pc_o is 0 absent redirects.

Structure
REQ-027 icode values (IJXX, ICALL, IRET) and status codes SHALL come from the shared define header; no local copies.
REQ-028 Counter table SHALL be one sub-module pht_2bit (read port, update port, sync reset); rest is flat.

Verification
REQ-029 Reset then nop stream with f_valP_i = PC+1 -> f_pc_o 0,1,2,... one per cycle.
REQ-030 Conditional jXX at 0x10, valC 0x40, fresh counters -> f_pred_taken_o=1, next f_pc_o 0x40; M reports cnd=0 -> mispredict_o=1, f_pc_o=M_valP_i, counter[0]=01.
REQ-031 Same jXX resolved not-taken twice -> counter 00, next fetch predicts not-taken, f_pc_o=valP; three taken -> saturates 11.
REQ-032 M mispredict and W_ret_i same cycle, W_valM 0x80, M_valC 0x40, cnd=1 -> f_pc_o=0x40.
REQ-033 F_stall_i=1 for 3 cycles with M update pending -> predPC unchanged, counter still updated, perf_jxx_o +1.
REQ-034 Preload perf_miss_o to 32'hFFFF_FFFF, force mispredict -> stays 32'hFFFF_FFFF.
